// File: rtl/pcie_dllp_scheduler_pkg.sv
// Shared DLLP definitions for the DLL TX scheduler: DLLP type codes, FC types,
// the 48-bit DLLP layout and scheduler state/source encodings.
package pcie_dllp_scheduler_pkg;

  localparam logic [7:0] DLLP_ACK       = 8'h00;
  localparam logic [7:0] DLLP_NAK       = 8'h10;
  localparam logic [7:0] DLLP_UPDFC_P   = 8'h80;
  localparam logic [7:0] DLLP_UPDFC_NP  = 8'h90;
  localparam logic [7:0] DLLP_UPDFC_CPL = 8'hA0;

  localparam logic [15:0] CRC16_POLY = 16'h100B;
  localparam logic [15:0] CRC16_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    FC_P    = 2'd0,
    FC_NP   = 2'd1,
    FC_CPL  = 2'd2,
    FC_RSVD = 2'd3
  } fc_type_e;

  typedef struct packed {
    logic [7:0]  dtype;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [15:0] crc;
  } dllp_t;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } sched_state_e;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_NAK,
    SRC_ACK,
    SRC_FC
  } src_e;

  function automatic logic [7:0] fc_dtype(fc_type_e t);
    case (t)
      FC_P:    return DLLP_UPDFC_P;
      FC_NP:   return DLLP_UPDFC_NP;
      default: return DLLP_UPDFC_CPL;
    endcase
  endfunction

  function automatic fc_type_e next_fc(fc_type_e t);
    case (t)
      FC_P:    return FC_NP;
      FC_NP:   return FC_CPL;
      default: return FC_P;
    endcase
  endfunction

endpackage

// File: rtl/pcie_dllp_scheduler_crc16.sv
// Combinational DLLP CRC16 over the 4 header bytes: byte0 first, each byte
// LSB first, complemented result.
module crc16_dllp
  import pcie_dllp_scheduler_pkg::*;
(
  input  logic [31:0] data,
  output logic [15:0] crc
);

  logic [15:0] c;
  logic [31:0] msg;
  logic [7:0]  byte_v;
  logic        fb;

  always_comb begin
    c      = CRC16_SEED;
    msg    = data;
    byte_v = '0;
    fb     = 1'b0;
    for (int unsigned b = 0; b < 4; b++) begin
      byte_v = msg[31:24];
      msg    = msg << 8;
      for (int unsigned k = 0; k < 8; k++) begin
        fb     = c[15] ^ byte_v[0];
        byte_v = byte_v >> 1;
        c      = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
      end
    end
    crc = ~c;
  end

endmodule

// File: rtl/pcie_dllp_scheduler.sv
// VC0 DLLP scheduler: coalesces Ack/Nak/UpdateFC requests, applies ack-latency
// and FC-refresh timers, and presents one CRC-protected DLLP at a time.
module pcie_dllp_scheduler
  import pcie_dllp_scheduler_pkg::*;
#(
  parameter int unsigned ACK_TIMER_CYCLES  = 64,
  parameter int unsigned ACK_COALESCE      = 4,
  parameter int unsigned FC_REFRESH_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ack_req_i,
  input  logic [11:0] ack_seq_i,
  input  logic        nak_req_i,
  input  logic [11:0] nak_seq_i,
  input  logic        fc_upd_req_i,
  input  logic [1:0]  fc_type_i,
  input  logic [7:0]  fc_hdr_i,
  input  logic [11:0] fc_data_i,
  output logic        dllp_valid_o,
  output logic [47:0] dllp_o,
  input  logic        dllp_ready_i
);

  localparam int unsigned ACK_TW = $clog2(ACK_TIMER_CYCLES + 1);
  localparam int unsigned REF_TW = (FC_REFRESH_CYCLES > 2) ? $clog2(FC_REFRESH_CYCLES) : 1;
  localparam logic [ACK_TW-1:0] ACK_TMAX = ACK_TW'(ACK_TIMER_CYCLES - 1);
  localparam logic [REF_TW-1:0] REF_MAX  = REF_TW'(FC_REFRESH_CYCLES - 1);

  sched_state_e state, state_d;
  dllp_t        dllp_q;

  logic              ack_pend;
  logic [11:0]       ack_seq;
  logic [2:0]        ack_cnt;
  logic [ACK_TW-1:0] ack_tmr;
  logic              nak_pend;
  logic [11:0]       nak_seq;
  logic [2:0]        fc_pend;
  logic [7:0]        fc_hdr  [3];
  logic [11:0]       fc_data [3];
  logic [REF_TW-1:0] ref_tmr;
  fc_type_e          rr_ptr;

  logic        ack_due, ref_wrap, load;
  logic        take_nak, take_ack, take_fc;
  fc_type_e    fc_c0, fc_c1, fc_c2, fc_sel;
  src_e        win_src;
  logic [31:0] win_payload;
  logic [15:0] win_crc;

  assign ack_due  = ack_pend && ((ack_tmr == ACK_TMAX) || (32'(ack_cnt) >= ACK_COALESCE));
  assign ref_wrap = (ref_tmr == REF_MAX);

  // Round-robin search starts at rr_ptr, which always names the type after the last one sent.
  always_comb begin
    fc_c0  = rr_ptr;
    fc_c1  = next_fc(fc_c0);
    fc_c2  = next_fc(fc_c1);
    fc_sel = fc_c0;
    if (fc_pend[fc_c0])      fc_sel = fc_c0;
    else if (fc_pend[fc_c1]) fc_sel = fc_c1;
    else if (fc_pend[fc_c2]) fc_sel = fc_c2;
  end

  always_comb begin
    win_src     = SRC_NONE;
    win_payload = '0;
    if (nak_pend) begin
      win_src     = SRC_NAK;
      win_payload = {DLLP_NAK, 8'h00, 4'h0, nak_seq};
    end else if (ack_due) begin
      win_src     = SRC_ACK;
      win_payload = {DLLP_ACK, 8'h00, 4'h0, ack_seq};
    end else if (|fc_pend) begin
      win_src     = SRC_FC;
      win_payload = {fc_dtype(fc_sel), 2'b00, fc_hdr[fc_sel][7:2],
                     fc_hdr[fc_sel][1:0], 2'b00, fc_data[fc_sel][11:8],
                     fc_data[fc_sel][7:0]};
    end
  end

  crc16_dllp u_crc (
    .data (win_payload),
    .crc  (win_crc)
  );

  always_comb begin
    state_d = state;
    load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_src != SRC_NONE) begin
          load    = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (dllp_ready_i) begin
          if (win_src != SRC_NONE) load = 1'b1;
          else                     state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign take_nak = load && (win_src == SRC_NAK);
  assign take_ack = load && (win_src == SRC_ACK);
  assign take_fc  = load && (win_src == SRC_FC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      dllp_q <= '0;
    end else begin
      state <= state_d;
      if (load) dllp_q <= {win_payload, win_crc};
    end
  end

  // A same-cycle load counts as the slot emptying, so a new request restarts count and timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_pend <= 1'b0;
      ack_seq  <= '0;
      ack_cnt  <= '0;
      ack_tmr  <= '0;
    end else if (nak_req_i) begin
      ack_pend <= 1'b0;
      ack_cnt  <= '0;
      ack_tmr  <= '0;
    end else if (ack_req_i) begin
      ack_pend <= 1'b1;
      ack_seq  <= ack_seq_i;
      if (!ack_pend || take_ack) begin
        ack_cnt <= 3'd1;
        ack_tmr <= '0;
      end else begin
        if (ack_cnt != 3'd7)     ack_cnt <= ack_cnt + 3'd1;
        if (ack_tmr != ACK_TMAX) ack_tmr <= ack_tmr + 1'b1;
      end
    end else if (take_ack) begin
      ack_pend <= 1'b0;
      ack_cnt  <= '0;
      ack_tmr  <= '0;
    end else if (ack_pend && (ack_tmr != ACK_TMAX)) begin
      ack_tmr <= ack_tmr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nak_pend <= 1'b0;
      nak_seq  <= '0;
    end else if (nak_req_i) begin
      nak_pend <= 1'b1;
      nak_seq  <= nak_seq_i;
    end else if (take_nak) begin
      nak_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc_pend <= '0;
      ref_tmr <= '0;
      rr_ptr  <= FC_P;
      for (int unsigned i = 0; i < 3; i++) begin
        fc_hdr[2'(i)]  <= '0;
        fc_data[2'(i)] <= '0;
      end
    end else begin
      ref_tmr <= ref_wrap ? '0 : ref_tmr + 1'b1;
      if (take_fc) rr_ptr <= next_fc(fc_sel);
      for (int unsigned i = 0; i < 3; i++) begin
        if (fc_upd_req_i && (fc_type_i == 2'(i))) begin
          fc_pend[2'(i)] <= 1'b1;
          fc_hdr[2'(i)]  <= fc_hdr_i;
          fc_data[2'(i)] <= fc_data_i;
        end else if (ref_wrap) begin
          fc_pend[2'(i)] <= 1'b1;
        end else if (take_fc && (fc_sel == 2'(i))) begin
          fc_pend[2'(i)] <= 1'b0;
        end
      end
    end
  end

  assign dllp_valid_o = (state == ST_HOLD);
  assign dllp_o       = dllp_q;

endmodule
